// File: rtl/vga_frame_capture.sv
// vga_frame_capture: decodes 800x600 VGA back to {I,R,G,B} VRAM writes and checks frame timing (optional CRC: VGA_FRAME_CAPTURE_CRC_EN)
module vga_frame_capture #(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 600,
  parameter int H_TOTAL = 1056,
  parameter int H_BP = 88,
  parameter int V_BP = 23,
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 4
) (
  input  logic clk,
  input  logic w_rst_n,
  input  logic i_hsync,
  input  logic i_vsync,
  input  logic [11:0] i_rgb,
  output logic o_write,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic o_frame_done,
  output logic o_locked,
  output logic o_err
`ifdef VGA_FRAME_CAPTURE_CRC_EN
  ,
  output logic [15:0] o_crc
`endif
);
  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);
  localparam int CW = $clog2(H_BP + 1);
  localparam int VW = $clog2(V_BP + 1);
  localparam int LW = $clog2(H_TOTAL + 2);
  typedef enum logic [2:0] {IDLE, VBP, HBP, ACTIVE, LWAIT, DONE} state_t;
  state_t st;
  logic hs_r, vs_r, hs_p, vs_p, lv;
  logic [11:0] rgb_r;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [CW-1:0] cnt;
  logic [VW-1:0] vcnt;
  logic [LW-1:0] lc;
  logic [ADDR_WIDTH-1:0] a;
  logic [3:0] dec;
  logic hs_rise, vs_rise, vs_fall, in_frame, err, unused;
  assign hs_rise = hs_r & ~hs_p;
  assign vs_rise = vs_r & ~vs_p;
  assign vs_fall = ~vs_r & vs_p;
  assign in_frame = st inside {VBP, HBP, ACTIVE, LWAIT};
  assign err = (st != IDLE && hs_rise && lv && lc != LW'(H_TOTAL)) || (vs_fall && in_frame);
  assign dec = {rgb_r[10], rgb_r[11], rgb_r[7], rgb_r[3]};
  assign unused = ^{rgb_r[9:8], rgb_r[6:4], rgb_r[2:0]};
`ifdef VGA_FRAME_CAPTURE_CRC_EN
  logic [15:0] crc;
  function automatic logic [15:0] crc_nib(input logic [15:0] c, input logic [3:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 3; i >= 0; i--) r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    return r;
  endfunction
`endif
  // input registers; syncs reset to their idle (high) level so release never fakes a rising edge
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      hs_r <= 1'b1;
      vs_r <= 1'b1;
      hs_p <= 1'b1;
      vs_p <= 1'b1;
      rgb_r <= '0;
    end else begin
      hs_r <= i_hsync;
      vs_r <= i_vsync;
      hs_p <= hs_r;
      vs_p <= vs_r;
      rgb_r <= i_rgb;
    end
  end
  // clocks since the last hsync rise; lv marks that a previous rise exists to measure from
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      lc <= '0;
      lv <= 1'b0;
    end else if (st == IDLE) begin
      lc <= '0;
      lv <= 1'b0;
    end else if (hs_rise) begin
      lc <= LW'(1);
      lv <= 1'b1;
    end else if (lc != '1) begin
      lc <= lc + 1'b1;
    end
  end
  // capture state machine with registered write port and status outputs
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      st <= IDLE;
      o_write <= 1'b0;
      o_addr <= '0;
      o_data <= '0;
      o_frame_done <= 1'b0;
      o_locked <= 1'b0;
      o_err <= 1'b0;
      x <= '0;
      y <= '0;
      cnt <= '0;
      vcnt <= '0;
      a <= '0;
`ifdef VGA_FRAME_CAPTURE_CRC_EN
      crc <= '0;
      o_crc <= '0;
`endif
    end else begin
      o_write <= 1'b0;
      o_frame_done <= 1'b0;
      o_err <= 1'b0;
      if (err) begin
        o_err <= 1'b1;
        o_locked <= 1'b0;
        st <= IDLE;
      end else begin
        case (st)
          IDLE: if (vs_rise) begin
            st <= VBP;
            vcnt <= '0;
            x <= '0;
            y <= '0;
            a <= '0;
`ifdef VGA_FRAME_CAPTURE_CRC_EN
            crc <= 16'hFFFF;
`endif
          end
          VBP: if (hs_rise) begin
            if (vcnt == VW'(V_BP - 1)) begin
              st <= HBP;
              cnt <= CW'(1);
            end else vcnt <= vcnt + 1'b1;
          end
          HBP: if (cnt == CW'(H_BP - 1)) begin
            st <= ACTIVE;
            x <= '0;
          end else cnt <= cnt + 1'b1;
          ACTIVE: begin
            o_write <= 1'b1;
            o_addr <= a;
            o_data <= dec;
            a <= a + 1'b1;
`ifdef VGA_FRAME_CAPTURE_CRC_EN
            crc <= crc_nib(crc, dec);
`endif
            x <= (x == XW'(H_ACTIVE - 1)) ? '0 : x + 1'b1;
            if (x == XW'(H_ACTIVE - 1)) begin
              if (y == YW'(V_ACTIVE - 1)) st <= DONE;
              else begin
                y <= y + 1'b1;
                st <= LWAIT;
              end
            end
          end
          LWAIT: if (hs_rise) begin
            st <= HBP;
            cnt <= CW'(1);
          end
          DONE: begin
            o_frame_done <= 1'b1;
            o_locked <= 1'b1;
`ifdef VGA_FRAME_CAPTURE_CRC_EN
            o_crc <= crc;
`endif
            st <= IDLE;
          end
          default: st <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/vga_frame_capture.md
Name: vga_frame_capture

Overview:
- Receiving end of the team's 800x600@60 VGA output path.
- Samples hsync/vsync/12-bit RGB on the pixel clock and decodes each pixel back to the 4-bit {I,R,G,B} VRAM format.
- Writes captured pixels through an sram-style write port (same addressing as the display VRAM), enabling loopback self-test of the display pipeline and frame grabbing.
- Checks line length and line count; reports lock and errors.

Parameters:
- H_ACTIVE, 800, active pixels per line
- V_ACTIVE, 600, active lines per frame
- H_TOTAL, 1056, clocks per line (hsync rise to rise)
- H_BP, 88, clocks from first high hsync sample to pixel x=0
- V_BP, 23, 1-based hsync rising edge after vsync rise that starts line y=0
- ADDR_WIDTH, 19, write address width
- DATA_WIDTH, 4, pixel width (fixed 4)

Ports:
- clk  in  1  pixel clock (40 MHz)
- w_rst_n  in  1  async active-low reset
- i_hsync  in  1  horizontal sync, active low, synchronous to clk
- i_vsync  in  1  vertical sync, active low, synchronous to clk
- i_rgb  in  12  {R[3:0],G[3:0],B[3:0]}
- o_write  out  1  pixel write strobe
- o_addr  out  ADDR_WIDTH  y*H_ACTIVE+x
- o_data  out  DATA_WIDTH  decoded pixel {I,R,G,B}
- o_frame_done  out  1  one-cycle pulse after last pixel of a good frame
- o_locked  out  1  set after a complete good frame
- o_err  out  1  one-cycle pulse on any timing violation

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (w_rst_n). All outputs reset to 0; all counters to 0; state IDLE.
- Input stage: i_hsync, i_vsync and i_rgb are registered once. Edges are detected on registered syncs, comparing the current sample with the previous one.
- Pixel decode: o_data = {rgb[10], rgb[11], rgb[7], rgb[3]}.
- Latency: a pixel on i_rgb appears on o_write/o_addr/o_data exactly 2 clocks later.
- States:
  - IDLE: wait for a vsync rising edge. Entered from reset or after an error.
  - VBP: count hsync rising edges. On edge number V_BP, go to HBP with y=0.
  - HBP: count clocks from the hsync-high sample (offset 0). At offset H_BP go to ACTIVE with x=0.
  - ACTIVE: one write per clock. x increments; o_addr increments by 1, starting at 0 at frame start.
    - At x=H_ACTIVE-1: if y=V_ACTIVE-1, go to DONE; else y++ and go to LWAIT.
  - LWAIT: wait for the next hsync rising edge, then go to HBP.
  - DONE: pulse o_frame_done one cycle after the last write; set o_locked; go to IDLE.
- Line length check:
  - Clocks between consecutive hsync rising edges are counted in every state except IDLE.
  - A count ≠ H_TOTAL pulses o_err, clears o_locked and forces IDLE. Any partially written frame is abandoned.
- Truncated frame: a vsync falling edge (vsync asserted) in VBP, HBP, ACTIVE or LWAIT pulses o_err, clears o_locked and forces IDLE.
- Extra lines after V_ACTIVE are ignored until the next vsync rise.
- Error/edge coincidence: an error coincident with an hsync edge takes priority; no write occurs that cycle.
- Write gating: o_write is 0 outside ACTIVE; o_addr and o_data hold their last values when o_write=0.
- Reset mid-frame: no writes until a full frame following the next vsync rising edge.
- o_addr max = 479999; no wrap.

Optional Feature:
- Macro: VGA_FRAME_CAPTURE_CRC_EN
- When defined:
  - Extra output o_crc [15:0] is present.
  - CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first) is computed over o_data nibbles on each write.
  - o_crc updates in the same cycle as o_frame_done and holds otherwise.
  - The running CRC reinitialises on entering VBP.
- When undefined: the port and the logic are absent; all other behaviour is identical.

Test Plan:
- Solid-colour frame: drive reference-timing frame with all pixels 12'hFFF → 480000 writes, addr 0..479999, data 4'hF, o_frame_done once, o_locked=1, o_err never.
- Pattern decode and alignment: pixel (x,y) = encoding of (x+y)%16 → first write addr 0 data 0, write at addr 801 data 2; output lags input by exactly 2 clocks.
- Short line: line 100 has 1050 clocks → o_err pulse, o_locked 0, no further writes until next vsync rise; the following good frame relocks.
- Early vsync: vsync asserted at line 300 → o_err, IDLE, no o_frame_done; next full frame captured normally.
- Reset mid-ACTIVE: w_rst_n low at pixel (400,200) → outputs 0 immediately; no writes until the following complete frame, which starts at addr 0.
- CRC (if enabled): all-zero frame → o_crc equals the software model value, and is identical on two consecutive frames.
